// File: rtl/slc3_pkg.sv
// slc3_pkg: shared SLC-3 datapath constants and condition-code type
package slc3_pkg;
  localparam int DATA_W = 16;
  localparam logic [2:0] R7_IDX = 3'd7;
  typedef struct packed {
    logic n;
    logic z;
    logic p;
  } nzp_t;
  localparam nzp_t NZP_RST = 3'b010;
endpackage

// File: rtl/slc3_reg_array.sv
// slc3_reg_array: register array with one synchronous write port and two asynchronous read ports
module slc3_reg_array #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++)
      regs_d[i] = Reset ? '0 : (we && wa == AW'(i)) ? wd : regs_q[i];
  end
  always_ff @(posedge Clk) regs_q <= regs_d;
  // Reads see the array before the edge; no write-through bypass.
  assign rd1 = regs_q[ra1];
  assign rd2 = regs_q[ra2];
endmodule

// File: rtl/slc3_regfile_ben.sv
// slc3_regfile_ben: SLC-3 register file, NZP condition codes and branch-enable register
module slc3_regfile_ben #(
  parameter int DATA_W   = slc3_pkg::DATA_W,
  parameter int NUM_REGS = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] Bus,
  input  logic [15:0]       IR,
  input  logic              LD_REG,
  input  logic              LD_CC,
  input  logic              LD_BEN,
  input  logic              DRMUX,
  input  logic              SR1MUX,
  output logic [DATA_W-1:0] SR1_OUT,
  output logic [DATA_W-1:0] SR2_OUT,
  output logic [2:0]        NZP,
  output logic              BEN
);
  import slc3_pkg::*;
  localparam int AW = $clog2(NUM_REGS);
  logic [AW-1:0] dr, sr1, sr2;
  nzp_t cc, nzp_d, nzp_q;
  logic ben_d, ben_q;
  always_comb begin
    dr = DRMUX ? AW'(R7_IDX) : IR[9 +: AW];
    sr1 = SR1MUX ? IR[9 +: AW] : IR[6 +: AW];
    sr2 = IR[0 +: AW];
    cc = '{n: Bus[DATA_W-1], z: ~|Bus, p: ~Bus[DATA_W-1] & |Bus};
    nzp_d = Reset ? NZP_RST : LD_CC ? cc : nzp_q;
    // BEN samples the NZP held before this edge, even when LD_CC fires together with it.
    ben_d = Reset ? 1'b0 : LD_BEN ? |(IR[11:9] & nzp_q) : ben_q;
  end
  always_ff @(posedge Clk) begin
    nzp_q <= nzp_d;
    ben_q <= ben_d;
  end
  slc3_reg_array #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .AW(AW)) u_regs (
    .Clk  (Clk),
    .Reset(Reset),
    .we   (LD_REG),
    .wa   (dr),
    .wd   (Bus),
    .ra1  (sr1),
    .ra2  (sr2),
    .rd1  (SR1_OUT),
    .rd2  (SR2_OUT)
  );
  assign NZP = nzp_q;
  assign BEN = ben_q;
endmodule
